sha256_stream_padder: RTL and testbench



---
 rtl/sha256_pkg.sv | 17 +
 rtl/sha256_byte_packer.sv | 54 +++++
 rtl/sha256_stream_padder.sv | 158 +++++++++++++++
 tb/tb_sha256_stream_padder.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message front end.
package sha256_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StData,
      StPad,
      StZero,
      StLenHi,
      StLenLo
   } sha256_state_e;

   localparam int unsigned SHA256_BLOCK_WORDS = 16;
   localparam int unsigned SHA256_LEN_IDX     = 14;
   localparam logic [7:0]  SHA256_PAD_BYTE    = 8'h80;

endpackage

// File: rtl/sha256_byte_packer.sv
// Packs DATA_W-bit big-endian beats into 32-bit words and inserts the 0x80 pad byte.
module sha256_byte_packer
   import sha256_pkg::*;
#(
   parameter int unsigned DATA_W = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      beat_en,
   input  logic [DATA_W-1:0]         beat_data,
   input  logic [$clog2(DATA_W/8):0] beat_nbytes,
   input  logic                      pad_en,
   output logic [31:0]               word,
   output logic                      word_full
);

   localparam int unsigned ALIGN = 32 - DATA_W;

   logic [31:0] acc_q;
   logic [2:0]  cnt_q;
   logic [5:0]  beat_bits;
   logic [31:0] beat_mask;
   logic [31:0] beat_word;
   logic [31:0] merged;
   logic [31:0] pad_word;
   logic [2:0]  merged_cnt;

   // Align the beat's valid bytes to the MSB side and drop them into the next free lanes.
   always_comb begin
      beat_bits  = 6'(beat_nbytes) << 3;
      beat_mask  = ~(32'hFFFF_FFFF >> beat_bits);
      beat_word  = (32'(beat_data) << ALIGN) & beat_mask;
      merged     = acc_q | (beat_word >> {cnt_q, 3'b000});
      merged_cnt = cnt_q + 3'(beat_nbytes);
      pad_word   = acc_q | ({SHA256_PAD_BYTE, 24'h0} >> {cnt_q, 3'b000});
      word_full  = (merged_cnt == 3'd4);
      word       = pad_en ? pad_word : merged;
   end

   // Accumulator clears whenever a complete word or the padded word leaves.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= '0;
         cnt_q <= '0;
      end else if (pad_en || (beat_en && word_full)) begin
         acc_q <= '0;
         cnt_q <= '0;
      end else if (beat_en) begin
         acc_q <= merged;
         cnt_q <= merged_cnt;
      end
   end

endmodule

// File: rtl/sha256_stream_padder.sv
// Streams a message in, applies SHA-256 padding and emits 32-bit schedule words W0..W15.
module sha256_stream_padder
   import sha256_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned LEN_W  = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [DATA_W-1:0]         in_data,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic                      in_last,
   input  logic [$clog2(DATA_W/8):0] in_nbytes,
   output logic [31:0]               w_data,
   output logic                      w_valid,
   input  logic                      w_ready,
   output logic [3:0]                w_idx,
   output logic                      w_last_blk,
   output logic                      busy,
   output logic                      len_err
);

   localparam int unsigned IDX_W        = $clog2(SHA256_BLOCK_WORDS);
   localparam logic [IDX_W-1:0] PAD_MAX  = IDX_W'(SHA256_LEN_IDX - 1);
   localparam logic [IDX_W-1:0] DATA_MAX = IDX_W'(SHA256_LEN_IDX - 2);

   sha256_state_e    state_q;
   logic [31:0]      w_data_q;
   logic             w_valid_q;
   logic [IDX_W-1:0] w_idx_q;
   logic             w_last_q;
   logic [LEN_W-1:0] len_q;
   logic             len_err_q;
   logic             blk_fin_q;

   logic             out_free;
   logic             beat;
   logic             take;
   logic             pad_en;
   logic [IDX_W-1:0] nidx;
   logic [5:0]       beat_bits;
   logic [LEN_W-1:0] len_base;
   logic [LEN_W:0]   len_sum;
   logic [63:0]      len64;
   logic [31:0]      pk_word;
   logic             pk_full;
   logic             zero_fin;

   // Handshake decode; nidx is the index the next loaded word will carry.
   always_comb begin
      out_free  = !w_valid_q || w_ready;
      in_ready  = !rst && ((state_q == StIdle) || (state_q == StData)) && out_free;
      beat      = in_valid && in_ready;
      take      = w_valid_q && w_ready;
      pad_en    = (state_q == StPad) && out_free;
      nidx      = take ? w_idx_q + 1'b1 : w_idx_q;
      beat_bits = 6'(in_nbytes) << 3;
      len_base  = (state_q == StIdle) ? '0 : len_q;
      len_sum   = {1'b0, len_base} + (LEN_W+1)'(beat_bits);
      len64     = 64'(len_q);
      // Wrapping to word 0 while zero-filling means we have entered the final block.
      zero_fin  = blk_fin_q || (nidx == '0);
   end

   sha256_byte_packer #(
      .DATA_W (DATA_W)
   ) u_packer (
      .clk         (clk),
      .rst         (rst),
      .beat_en     (beat),
      .beat_data   (in_data),
      .beat_nbytes (in_nbytes),
      .pad_en      (pad_en),
      .word        (pk_word),
      .word_full   (pk_full)
   );

   // Control FSM with the single-entry output register and length counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         w_data_q  <= '0;
         w_valid_q <= 1'b0;
         w_idx_q   <= '0;
         w_last_q  <= 1'b0;
         len_q     <= '0;
         len_err_q <= 1'b0;
         blk_fin_q <= 1'b0;
      end else begin
         if (take) begin
            w_valid_q <= 1'b0;
            w_idx_q   <= w_idx_q + 1'b1;
         end
         case (state_q)
            StIdle, StData: begin
               if (beat) begin
                  len_q     <= len_sum[LEN_W] ? '1 : len_sum[LEN_W-1:0];
                  // First beat of a message clears the sticky overflow flag.
                  len_err_q <= len_sum[LEN_W] || ((state_q == StData) && len_err_q);
                  if (pk_full) begin
                     w_data_q  <= pk_word;
                     w_valid_q <= 1'b1;
                     // Only the word completed by the last beat can know it is final.
                     w_last_q  <= in_last && (nidx <= DATA_MAX);
                  end
                  state_q <= in_last ? StPad : StData;
               end
            end
            StPad: begin
               if (out_free) begin
                  w_data_q  <= pk_word;
                  w_valid_q <= 1'b1;
                  w_last_q  <= (nidx <= PAD_MAX);
                  blk_fin_q <= (nidx <= PAD_MAX);
                  state_q   <= (nidx == PAD_MAX) ? StLenHi : StZero;
               end
            end
            StZero: begin
               if (out_free) begin
                  w_data_q  <= '0;
                  w_valid_q <= 1'b1;
                  w_last_q  <= zero_fin;
                  blk_fin_q <= zero_fin;
                  if (zero_fin && (nidx == PAD_MAX)) begin
                     state_q <= StLenHi;
                  end
               end
            end
            StLenHi: begin
               if (out_free) begin
                  w_data_q  <= len64[63:32];
                  w_valid_q <= 1'b1;
                  w_last_q  <= 1'b1;
                  state_q   <= StLenLo;
               end
            end
            StLenLo: begin
               if (out_free) begin
                  w_data_q  <= len64[31:0];
                  w_valid_q <= 1'b1;
                  w_last_q  <= 1'b1;
                  state_q   <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign w_data     = w_data_q;
   assign w_valid    = w_valid_q;
   assign w_idx      = w_idx_q;
   assign w_last_blk = w_last_q;
   assign len_err    = len_err_q;
   assign busy       = (state_q != StIdle) || w_valid_q;

endmodule

// File: tb/tb_sha256_stream_padder.sv
// Scoreboard bench: four padder instances (DATA_W 8/32/16, and LEN_W=8) share one stimulus bus.
module tb_sha256_stream_padder;

   typedef struct {
      logic [31:0] d;
      logic [3:0]  idx;
      logic        last;
      bit          chk_last;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [31:0] in_data;
   logic        in_valid;
   logic        in_last;
   logic [2:0]  in_nbytes;
   logic        w_ready;
   logic [1:0]  sel;

   logic        rdy_a  [4];
   logic [31:0] wd_a   [4];
   logic        wv_a   [4];
   logic [3:0]  wi_a   [4];
   logic        wl_a   [4];
   logic        busy_a [4];
   logic        le_a   [4];

   logic        in_ready_m;
   logic [31:0] w_data_m;
   logic        w_valid_m;
   logic [3:0]  w_idx_m;
   logic        w_last_m;
   logic        busy_m;
   logic        len_err_m;

   int          n_checks = 0;
   int          n_errors = 0;
   int          ready_duty = 100;
   exp_t        q[$];
   logic [7:0]  msg[$];
   bit          hold_v = 0;
   logic [31:0] hold_d = '0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int unsigned DW = (g == 1) ? 32 : (g == 2) ? 16 : 8;
      localparam int unsigned LW = (g == 3) ? 8 : 32;
      sha256_stream_padder #(
         .DATA_W (DW),
         .LEN_W  (LW)
      ) u_dut (
         .clk        (clk),
         .rst        (rst),
         .in_data    (in_data[DW-1:0]),
         .in_valid   (in_valid && (sel == 2'(g))),
         .in_ready   (rdy_a[g]),
         .in_last    (in_last),
         .in_nbytes  (in_nbytes[$clog2(DW/8):0]),
         .w_data     (wd_a[g]),
         .w_valid    (wv_a[g]),
         .w_ready    (w_ready && (sel == 2'(g))),
         .w_idx      (wi_a[g]),
         .w_last_blk (wl_a[g]),
         .busy       (busy_a[g]),
         .len_err    (le_a[g])
      );
   end

   always_comb begin
      in_ready_m = rdy_a[sel];
      w_data_m   = wd_a[sel];
      w_valid_m  = wv_a[sel];
      w_idx_m    = wi_a[sel];
      w_last_m   = wl_a[sel];
      busy_m     = busy_a[sel];
      len_err_m  = le_a[sel];
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference padding of the bytes in msg; bit length saturates at 2^len_w - 1.
   task automatic push_expected(input int len_w);
      logic [7:0]  p[$];
      logic [63:0] bits;
      int          nwords;
      exp_t        e;
      p = msg;
      p.push_back(8'h80);
      while (p.size() % 64 != 56) p.push_back(8'h00);
      bits = 64'(msg.size()) * 64'd8;
      if (len_w < 64 && bits >= (64'd1 << len_w)) bits = (64'd1 << len_w) - 64'd1;
      for (int i = 0; i < 8; i++) p.push_back(bits[63-8*i -: 8]);
      nwords = p.size() / 4;
      for (int w = 0; w < nwords; w++) begin
         e.d        = {p[4*w], p[4*w+1], p[4*w+2], p[4*w+3]};
         e.idx      = 4'(w % 16);
         e.last     = (w >= nwords - 16);
         // Pure data words of the final block go out before the tail is seen.
         e.chk_last = !((4*w + 3 < msg.size()) && e.last);
         q.push_back(e);
      end
   endtask

   // Drive msg as big-endian beats of dw bytes, optionally with random idle gaps.
   task automatic send_beats(input int dw, input int gap_pct, input int max_beats);
      int pos = 0;
      int nbeats = 0;
      do begin
         int          nb;
         int          t;
         bit          acc;
         logic [31:0] d;
         nb = msg.size() - pos;
         if (nb > dw) nb = dw;
         d = '0;
         for (int k = 0; k < nb; k++) d |= 32'(msg[pos+k]) << (8 * (dw - 1 - k));
         while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
         end
         in_data   = d;
         in_nbytes = 3'(nb);
         in_last   = (pos + nb == msg.size());
         in_valid  = 1'b1;
         t = 0;
         acc = 0;
         while (!acc && t < 200) begin
            @(negedge clk);
            acc = in_ready_m;
            @(posedge clk);
            #1;
            t++;
         end
         if (!acc) begin
            check("beat_accept_timeout", 64'(t), 64'd0);
            in_valid = 1'b0;
            return;
         end
         pos += nb;
         nbeats++;
      end while (pos < msg.size() && nbeats < max_beats);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int t = 0;
      while ((q.size() != 0 || busy_m) && t < 3000) begin
         @(posedge clk);
         #1;
         t++;
      end
      check({tag, "_done"}, 64'(t < 3000), 64'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"}, 64'(in_ready_m), 64'd0);
      check({tag, "_w_valid"}, 64'(w_valid_m), 64'd0);
      check({tag, "_w_data"}, 64'(w_data_m), 64'd0);
      check({tag, "_w_idx"}, 64'(w_idx_m), 64'd0);
      check({tag, "_w_last_blk"}, 64'(w_last_m), 64'd0);
      check({tag, "_busy"}, 64'(busy_m), 64'd0);
      check({tag, "_len_err"}, 64'(len_err_m), 64'd0);
   endtask

   task automatic load_abc();
      msg = {};
      msg.push_back(8'h61);
      msg.push_back(8'h62);
      msg.push_back(8'h63);
   endtask

   // Output monitor: pops the scoreboard on every handshake and checks hold stability.
   always @(negedge clk) begin
      if (rst) begin
         hold_v = 0;
      end else begin
         if (hold_v && w_valid_m) check("hold_stable", 64'(w_data_m), 64'(hold_d));
         if (w_valid_m && w_ready) begin
            if (q.size() == 0) begin
               check("unexpected_word", 64'(q.size()), 64'd1);
            end else begin
               exp_t e;
               e = q.pop_front();
               check("w_data", 64'(w_data_m), 64'(e.d));
               check("w_idx", 64'(w_idx_m), 64'(e.idx));
               if (e.chk_last) check("w_last_blk", 64'(w_last_m), 64'(e.last));
            end
         end
         hold_v = w_valid_m && !w_ready;
         hold_d = w_data_m;
      end
   end

   initial begin
      rst       = 1'b1;
      in_data   = '0;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      in_nbytes = '0;
      w_ready   = 1'b0;
      sel       = 2'd0;
      fork
         forever begin
            @(posedge clk);
            #1;
            w_ready = ($urandom_range(99) < ready_duty);
         end
      join_none

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 1'b0;
      #1;
      check("idle_in_ready", 64'(in_ready_m), 64'd1);

      // "abc", DATA_W=8
      load_abc();
      push_expected(32);
      send_beats(1, 0, 1000);
      wait_done("abc8");
      check("abc8_len_err", 64'(len_err_m), 64'd0);

      // Empty message, DATA_W=32
      sel = 2'd1;
      msg = {};
      push_expected(32);
      send_beats(4, 0, 1000);
      wait_done("empty32");

      // 56 bytes, DATA_W=32: 0x80 lands at word 14, two blocks
      msg = {};
      for (int i = 0; i < 56; i++) msg.push_back(8'(i * 7 + 3));
      push_expected(32);
      send_beats(4, 0, 1000);
      wait_done("b56_32");

      // 55 bytes, DATA_W=16, final beat carries one byte
      sel = 2'd2;
      msg = {};
      for (int i = 0; i < 55; i++) msg.push_back(8'(i * 13 + 5));
      push_expected(32);
      send_beats(2, 0, 1000);
      wait_done("b55_16");

      // Backpressure and input gaps on "abc"
      sel = 2'd0;
      ready_duty = 30;
      load_abc();
      push_expected(32);
      send_beats(1, 40, 1000);
      wait_done("abc_bp");
      ready_duty = 100;
      @(posedge clk);
      #1;

      // Reset after 5 bytes of a 10-byte message
      msg = {};
      for (int i = 0; i < 10; i++) msg.push_back(8'(8'hA0 + i));
      begin
         exp_t e;
         e.d        = {msg[0], msg[1], msg[2], msg[3]};
         e.idx      = 4'd0;
         e.last     = 1'b0;
         e.chk_last = 1;
         q.push_back(e);
      end
      send_beats(1, 0, 5);
      repeat (3) @(posedge clk);
      #1;
      check("pre_reset_busy", 64'(busy_m), 64'd1);
      check("pre_reset_queue", 64'(q.size()), 64'd0);
      rst = 1'b1;
      #1;
      check_reset_outputs("mid_reset");
      @(posedge clk);
      #1;
      rst = 1'b0;
      load_abc();
      push_expected(32);
      send_beats(1, 0, 1000);
      wait_done("abc_after_rst");

      // LEN_W=8 overflow: 32 bytes = 256 bits saturates to 0xFF
      sel = 2'd3;
      msg = {};
      for (int i = 0; i < 32; i++) msg.push_back(8'(i + 1));
      push_expected(8);
      send_beats(1, 0, 1000);
      wait_done("ovf8");
      check("ovf8_len_err", 64'(len_err_m), 64'd1);

      // Next message clears the sticky flag
      load_abc();
      push_expected(8);
      send_beats(1, 0, 1000);
      wait_done("abc_lw8");
      check("abc_lw8_len_err", 64'(len_err_m), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
